beam_dac_queue: RTL and testbench
=================================

# beam_dac_queue

Buffers Vectrex beam samples (`beam_h_out`, `beam_v_out`, `beam_blank_n`) and hands them to the SPI DAC serializer for the external X/Y vector monitor.
- Scales and axis-swaps each sample into 12-bit DAC words.
- Suppresses redundant samples with a deadband filter.
- Queues accepted samples in a FIFO and releases them over a valid/ready handshake.
- Re-sends the last position on idle so the monitor keeps refreshing.

## Interface
Parameters:
- DEPTH, 16: FIFO entries, power of two, ≥4.
- DEADBAND, 2: minimum per-axis change (scaled 10-bit units) that forces a push.
- KEEPALIVE, 4096: idle cycles before the last sample is re-pushed; 0 disables.

Ports:
- clock  in  1  system clock (clk_sys).
- reset_n  in  1  asynchronous, active-low reset.
- sample_en  in  1  sample strobe; inputs are valid when high.
- beam_h  in  10  horizontal beam position, unsigned.
- beam_v  in  10  vertical beam position, unsigned.
- beam_blank_n  in  1  beam on when high.
- out_ready  in  1  serializer is ready to take a word.
- out_valid  out  1  dac_x/dac_y/dac_z hold a valid word.
- dac_x  out  12  X DAC word.
- dac_y  out  12  Y DAC word.
- dac_z  out  12  intensity word.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a sample is dropped.
- drop_count  out  16  number of dropped samples, saturating.

## Operation
- Scaling (stage S1, registered):
  - h_div = (beam_h>>1)+384 and v_div = (beam_v>>1)+384, both 10-bit; results range 384..895, so no wrap.
  - X is derived from V and Y from H (axes swapped).
  - dac_x = {~v_div, 2'b00}; dac_y = {h_div, 2'b00}; dac_z = {12{beam_blank_n}}.
- Push decision, made in S1 for a sample with sample_en=1. The sample is pushed if any of these holds:
  - the last-pushed register is invalid (first sample after reset);
  - blank_n differs from the last pushed value;
  - |h_div − last_h| > DEADBAND or |v_div − last_v| > DEADBAND (11-bit signed difference).
- On each push: update the last-pushed register and clear the idle counter.
- Keepalive:
  - The idle counter increments each cycle in which there is no push, while the FIFO is empty and out_valid=0.
  - When it reaches KEEPALIVE and the last-pushed register is valid, re-push the last sample and clear the counter.
  - A real push in the same cycle takes priority; no duplicate is pushed.
- FIFO: DEPTH×25-bit entries {blank, h_div, v_div}; write and read pointers of $clog2(DEPTH)+1 bits.
- Full FIFO:
  - A push with no pop in the same cycle is dropped: overflow←1, drop_count+1 (saturates at 16'hFFFF), last-pushed register unchanged.
  - A push with a pop in the same cycle is accepted.
- Output register:
  - Loads the FIFO head whenever out_valid=0, or out_valid & out_ready.
  - Holds stable while out_valid & ~out_ready.
- Reset:
  - out_valid=0; dac_x/dac_y/dac_z=0; fifo_level=0; overflow=0; drop_count=0.
  - Last-pushed register invalid; idle counter 0; pointers 0.
  - Reset asserted mid-operation discards all queued samples immediately.

## Timing
- With an empty FIFO and idle output: sample_en in cycle N → FIFO write at the end of N+1 → out_valid=1 in N+2.
- Throughput: one word per cycle while out_ready is held high.
- fifo_level reflects the write and read of a given edge after that same edge.
- A transfer completes on a clock edge where out_valid & out_ready; the next word is shown on the following cycle if the FIFO is non-empty. There are no bubbles during back-to-back reads.
- overflow and drop_count update in the cycle the drop is decided (N+1).

## Structure
- Shared package beam_dac_pkg:
  - sample_t struct {blank, h[9:0], v[9:0]};
  - SCALE_OFFSET=384;
  - DAC_W=12, BEAM_W=10.
- One natural sub-module: sync_fifo (DEPTH, width 25), containing the pointers, full/empty logic and level.
- Scaling, filter, keepalive and output register live in beam_dac_queue.

## Test plan
- Reset, then sample_en with h=0, v=0, blank_n=1 → two cycles later out_valid=1, dac_x=12'h9FC, dac_y=12'h600, dac_z=12'hFFF.
- h=1023, v=1023, blank_n=0 as the first sample → dac_x=12'h200, dac_y=12'hDFC, dac_z=12'h000.
- Repeat h=100 with v stepping by 2 (DEADBAND=2) for 10 strobes → only the first sample is pushed; a step of 6 pushes again; toggling blank_n with fixed position always pushes.
- out_ready=0 with 20 distinct samples, DEPTH=16:
  - fifo_level=16, overflow=1, drop_count=4;
  - output word held stable throughout;
  - out_ready=1 then drains 16 words in order, one per cycle.
- KEEPALIVE=8, one sample then idle → the same word is re-emitted every 8+ cycles; with KEEPALIVE=0 there are no re-sends.
- Assert reset_n=0 with 5 entries queued → outputs and counters are 0 asynchronously; after release, the first sample is pushed even if identical to the pre-reset sample.

Source files
------------

// File: rtl/beam_dac_pkg.sv
// Shared types and helpers for the Vectrex beam-to-DAC queue.
package beam_dac_pkg;

  localparam int DAC_W  = 12;
  localparam int BEAM_W = 10;
  localparam logic [BEAM_W-1:0] SCALE_OFFSET = 10'd384;

  typedef struct packed {
    logic              blank;
    logic [BEAM_W-1:0] h;
    logic [BEAM_W-1:0] v;
  } sample_t;

  // Halve the beam coordinate and centre it; 0..1023 maps onto 384..895.
  function automatic logic [BEAM_W-1:0] scale_axis(input logic [BEAM_W-1:0] raw);
    return (raw >> 1) + SCALE_OFFSET;
  endfunction

  function automatic logic [BEAM_W:0] axis_delta(input logic [BEAM_W-1:0] a,
                                                 input logic [BEAM_W-1:0] b);
    logic [BEAM_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[BEAM_W] ? (~d + {{BEAM_W{1'b0}}, 1'b1}) : d;
  endfunction

endpackage

// File: rtl/beam_dac_queue_sync_fifo.sv
// Synchronous FIFO with extended pointers; exposes the entry behind the head
// so the consumer can refill its output register without a bubble.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_next_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW-1:0]    w_next_idx;

  // Pointer update; reset discards everything queued.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= {(AW + 1){1'b0}};
      r_rd_ptr <= {(AW + 1){1'b0}};
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage array write port.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign w_next_idx  = r_rd_ptr[AW-1:0] + AW'(1);
  assign o_next_data = r_mem[w_next_idx];
  assign o_level     = r_wr_ptr - r_rd_ptr;
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (o_level == LEVEL_FULL);

endmodule

// File: rtl/beam_dac_queue.sv
// Scales, deadband-filters and queues Vectrex beam samples for the SPI DAC
// serializer, re-sending the last position when the stream goes idle.
module beam_dac_queue
  import beam_dac_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DEADBAND  = 2,
  parameter int KEEPALIVE = 4096
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   sample_en,
  input  logic [BEAM_W-1:0]      beam_h,
  input  logic [BEAM_W-1:0]      beam_v,
  input  logic                   beam_blank_n,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DAC_W-1:0]       dac_x,
  output logic [DAC_W-1:0]       dac_y,
  output logic [DAC_W-1:0]       dac_z,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [15:0]            drop_count
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int IW = (KEEPALIVE > 0) ? $clog2(KEEPALIVE + 1) : 1;
  localparam logic [IW-1:0]     IDLE_LIMIT = IW'(KEEPALIVE);
  localparam logic [BEAM_W:0]   DB_LIMIT   = (BEAM_W + 1)'(DEADBAND);

  logic              r_s1_valid;
  sample_t           r_s1;
  logic              r_last_valid;
  sample_t           r_last;
  logic [IW-1:0]     r_idle;
  logic              r_out_valid;
  logic [DAC_W-1:0]  r_dac_x;
  logic [DAC_W-1:0]  r_dac_y;
  logic [DAC_W-1:0]  r_dac_z;
  logic              r_overflow;
  logic [15:0]       r_drop_count;

  logic [BEAM_W:0]   w_dh;
  logic [BEAM_W:0]   w_dv;
  logic              w_real_push;
  logic              w_keep_push;
  logic              w_push;
  sample_t           w_push_data;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_drop;
  logic              w_load;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  sample_t           w_next_data;
  sample_t           w_head;
  logic [LW-1:0]     w_level;
  logic [LW-1:0]     w_level_next;
  logic [LW-1:0]     w_remaining;

  // S1: capture the scaled sample one cycle after the strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '{blank: 1'b0, h: {BEAM_W{1'b0}}, v: {BEAM_W{1'b0}}};
    end else begin
      r_s1_valid <= sample_en;
      if (sample_en) begin
        r_s1 <= '{blank: beam_blank_n, h: scale_axis(beam_h), v: scale_axis(beam_v)};
      end
    end
  end

  // Push decision, keepalive injection, drop detection and next output head.
  always_comb begin
    w_dh        = axis_delta(r_s1.h, r_last.h);
    w_dv        = axis_delta(r_s1.v, r_last.v);
    w_real_push = 1'b0;
    if (r_s1_valid) begin
      w_real_push = !r_last_valid || (r_s1.blank != r_last.blank) ||
                    (w_dh > DB_LIMIT) || (w_dv > DB_LIMIT);
    end else begin
      w_real_push = 1'b0;
    end
    w_keep_push  = (KEEPALIVE != 0) && !w_real_push && r_last_valid && (r_idle == IDLE_LIMIT);
    w_push       = w_real_push || w_keep_push;
    w_push_data  = w_real_push ? r_s1 : r_last;
    w_pop        = r_out_valid && out_ready;
    w_wr_en      = w_push && (!w_fifo_full || w_pop);
    w_drop       = w_push && w_fifo_full && !w_pop;
    w_load       = !r_out_valid || out_ready;
    w_level_next = w_level + LW'(w_wr_en) - LW'(w_pop);
    w_remaining  = w_level - LW'(w_pop);
    // When nothing else is queued, the word being written this edge becomes the head.
    w_head       = (w_remaining == {LW{1'b0}}) ? w_push_data : w_next_data;
  end

  // Last-pushed register and idle counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_valid <= 1'b0;
      r_last       <= '{blank: 1'b0, h: {BEAM_W{1'b0}}, v: {BEAM_W{1'b0}}};
      r_idle       <= {IW{1'b0}};
    end else if (w_wr_en) begin
      r_last_valid <= 1'b1;
      r_last       <= w_push_data;
      r_idle       <= {IW{1'b0}};
    end else if (w_fifo_empty && !r_out_valid && (r_idle != IDLE_LIMIT)) begin
      r_idle <= r_idle + IW'(1);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Output register mirrors the FIFO head; the entry is popped on transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_dac_x     <= {DAC_W{1'b0}};
      r_dac_y     <= {DAC_W{1'b0}};
      r_dac_z     <= {DAC_W{1'b0}};
    end else if (w_load) begin
      r_out_valid <= (w_level_next != {LW{1'b0}});
      if (w_level_next != {LW{1'b0}}) begin
        r_dac_x <= {~w_head.v, 2'b00};
        r_dac_y <= {w_head.h, 2'b00};
        r_dac_z <= {DAC_W{w_head.blank}};
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(sample_t))
  ) u_fifo (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_wr_en     (w_wr_en),
    .i_wr_data   (w_push_data),
    .i_rd_en     (w_pop),
    .o_next_data (w_next_data),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_level     (w_level)
  );

  assign out_valid  = r_out_valid;
  assign dac_x      = r_dac_x;
  assign dac_y      = r_dac_y;
  assign dac_z      = r_dac_z;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_beam_dac_queue.sv
// Scoreboard bench for beam_dac_queue: a queue-level model predicts every
// emitted DAC word, occupancy, drops and keepalive re-sends.
module tb_beam_dac_queue;
  localparam int DEPTH    = 16;
  localparam int DEADBAND = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        sample_en_k = 1'b0;
  logic [9:0]  beam_h = 10'd0;
  logic [9:0]  beam_v = 10'd0;
  logic        beam_blank_n = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_ready_k = 1'b1;

  logic        out_valid, overflow, k_valid, k_ovf;
  logic [11:0] dac_x, dac_y, dac_z, k_x, k_y, k_z;
  logic [4:0]  fifo_level, k_level;
  logic [15:0] drop_count, k_drops;

  beam_dac_queue #(.DEPTH(DEPTH), .DEADBAND(DEADBAND), .KEEPALIVE(0)) dut (
    .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .beam_h(beam_h),
    .beam_v(beam_v), .beam_blank_n(beam_blank_n), .out_ready(out_ready),
    .out_valid(out_valid), .dac_x(dac_x), .dac_y(dac_y), .dac_z(dac_z),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count));

  beam_dac_queue #(.DEPTH(DEPTH), .DEADBAND(DEADBAND), .KEEPALIVE(8)) dut_k (
    .clock(clock), .reset_n(reset_n), .sample_en(sample_en_k), .beam_h(beam_h),
    .beam_v(beam_v), .beam_blank_n(beam_blank_n), .out_ready(out_ready_k),
    .out_valid(k_valid), .dac_x(k_x), .dac_y(k_y), .dac_z(k_z),
    .fifo_level(k_level), .overflow(k_ovf), .drop_count(k_drops));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_a = 0;
  logic [35:0] sb[$];
  int k_times[$];
  bit k_en = 1'b0;
  logic [35:0] k_word = 36'd0;

  // Reference-model state: queued word count, last accepted sample, pending strobe.
  int  m_level = 0;
  bit  m_ovf = 1'b0;
  int  m_drops = 0;
  bit  m_pend = 1'b0;
  int  m_ph = 0, m_pv = 0;
  bit  m_pb = 1'b0;
  bit  m_lok = 1'b0;
  int  m_lh = 0, m_lv = 0;
  bit  m_lb = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int scaled(input int raw);
    return raw / 2 + 384;
  endfunction

  function automatic logic [35:0] word_from_scaled(input int hd, input int vd, input bit b);
    int x, y;
    x = (1023 - vd) * 4;
    y = hd * 4;
    return {12'(x), 12'(y), (b ? 12'hFFF : 12'h000)};
  endfunction

  function automatic logic [35:0] word_of(input int h, input int v, input bit b);
    return word_from_scaled(scaled(h), scaled(v), b);
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic model_step();
    bit pop, push;
    if (!reset_n) begin
      m_level = 0; m_ovf = 1'b0; m_drops = 0; m_pend = 1'b0; m_lok = 1'b0;
      sb.delete();
    end else begin
      pop = (m_level > 0) && out_ready;
      if (pop) m_level--;
      if (m_pend) begin
        push = !m_lok || (m_pb != m_lb) || (iabs(m_ph - m_lh) > DEADBAND) ||
               (iabs(m_pv - m_lv) > DEADBAND);
        if (push && m_level == DEPTH) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else if (push) begin
          m_level++;
          sb.push_back(word_from_scaled(m_ph, m_pv, m_pb));
          m_lok = 1'b1; m_lh = m_ph; m_lv = m_pv; m_lb = m_pb;
        end
      end
      m_pend = sample_en;
      m_ph = scaled(int'(beam_h));
      m_pv = scaled(int'(beam_v));
      m_pb = beam_blank_n;
    end
  endtask

  task automatic mon_step();
    logic [35:0] exp;
    check("fifo_level", 64'(fifo_level), 64'(m_level));
    check("out_valid", 64'(out_valid), 64'(m_level != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drops));
    if (out_valid && out_ready) begin
      xfer_a++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word actual=%0h expected=none", {dac_x, dac_y, dac_z});
      end else begin
        exp = sb.pop_front();
        check("word", 64'({dac_x, dac_y, dac_z}), 64'(exp));
      end
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    model_step();
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) mon_step();
  end

  // Keepalive instance monitor: records re-send times and checks the word.
  initial forever begin
    @(negedge clock);
    if (reset_n && k_en) begin
      check("ka_overflow", 64'(k_ovf), 64'd0);
      check("ka_level_small", 64'(k_level <= 5'd1), 64'd1);
      if (k_valid && out_ready_k) begin
        k_times.push_back(cyc);
        check("ka_word", 64'({k_x, k_y, k_z}), 64'(k_word));
        check("ka_drops", 64'(k_drops), 64'd0);
      end
    end
  end

  task automatic drive(input bit en, input int h, input int v, input bit b);
    @(posedge clock); #1;
    sample_en = en; beam_h = 10'(h); beam_v = 10'(v); beam_blank_n = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      sample_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; sample_en = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int base, rh, rv, vcnt;
    bit rb;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_dac", 64'({dac_x, dac_y, dac_z}), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf_drops", 64'({overflow, drop_count}), 64'd0);

    // First sample latency and origin scaling.
    drive(1'b1, 0, 0, 1'b1);
    idle(1);
    @(negedge clock);
    check("lat_valid_n1", 64'(out_valid), 64'd0);
    @(negedge clock);
    check("lat_valid_n2", 64'(out_valid), 64'd1);
    check("origin_word", 64'({dac_x, dac_y, dac_z}), 64'({12'h9FC, 12'h600, 12'hFFF}));
    idle(1);
    out_ready = 1'b1;
    idle(3);

    // Far corner, blanked, as the first sample after reset.
    do_reset();
    drive(1'b1, 1023, 1023, 1'b0);
    idle(1);
    @(negedge clock);
    @(negedge clock);
    check("corner_word", 64'({dac_x, dac_y, dac_z}), 64'({12'h200, 12'hDFC, 12'h000}));
    idle(3);

    // Deadband: jitter within 2 scaled units is suppressed, a step of 3 is not.
    base = xfer_a;
    for (int i = 0; i < 10; i++) drive(1'b1, 100, (i % 2 == 1) ? 204 : 200, 1'b1);
    drive(1'b1, 100, 206, 1'b1);
    idle(6);
    check("deadband_pushes", 64'(xfer_a - base), 64'd2);
    base = xfer_a;
    for (int i = 0; i < 4; i++) drive(1'b1, 100, 206, (i % 2 == 1));
    idle(6);
    check("blank_toggle_pushes", 64'(xfer_a - base), 64'd4);

    // Overflow: 20 distinct samples with the serializer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i * 48, 500, 1'b1);
      if (i >= 3) begin
        @(negedge clock);
        check("stall_held", 64'({out_valid, dac_x, dac_y, dac_z}), 64'({1'b1, word_of(0, 500, 1'b1)}));
      end
    end
    idle(3);
    @(negedge clock);
    check("full_level", 64'(fifo_level), 64'd16);
    check("full_overflow", 64'(overflow), 64'd1);
    check("full_drops", 64'(drop_count), 64'd4);
    idle(1);
    out_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (out_valid) vcnt++;
    end
    check("drain_back_to_back", 64'(vcnt), 64'd16);
    @(negedge clock);
    check("drain_empty", 64'(out_valid), 64'd0);

    // Reset with entries queued; identical sample afterwards must still push.
    idle(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 10 + i * 20, 700, 1'b1);
    idle(2);
    @(negedge clock);
    check("pre_rst_level", 64'(fifo_level), 64'd5);
    check("pre_rst_overflow", 64'(overflow), 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_outputs", 64'({out_valid, dac_x, dac_y, dac_z}), 64'd0);
    check("async_rst_counts", 64'({fifo_level, overflow, drop_count}), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    drive(1'b1, 90, 700, 1'b1);
    idle(1);
    @(negedge clock);
    @(negedge clock);
    check("post_rst_word", 64'({out_valid, dac_x, dac_y, dac_z}), 64'({1'b1, word_of(90, 700, 1'b1)}));
    idle(1);
    out_ready = 1'b1;
    idle(3);

    // Keepalive: period 8 re-sends, period 0 stays silent.
    do_reset();
    k_times.delete();
    k_word = word_of(300, 300, 1'b1);
    k_en = 1'b1;
    base = xfer_a;
    drive(1'b1, 300, 300, 1'b1);
    sample_en_k = 1'b1;
    idle(1);
    sample_en_k = 1'b0;
    idle(45);
    k_en = 1'b0;
    check("ka_resend_count", 64'(k_times.size() >= 3), 64'd1);
    for (int i = 1; i < k_times.size(); i++) begin
      check("ka_gap", 64'((k_times[i] - k_times[i-1] >= 9) && (k_times[i] - k_times[i-1] <= 12)), 64'd1);
    end
    check("ka_disabled", 64'(xfer_a - base), 64'd1);

    // Randomized traffic: heavy then light backpressure.
    rh = 512; rv = 512; rb = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rh = int'($urandom_range(0, 1023));
        rv = int'($urandom_range(0, 1023));
      end else begin
        rh = rh + int'($urandom_range(0, 6)) - 3;
        rv = rv + int'($urandom_range(0, 6)) - 3;
        if (rh < 0) rh = 0;
        if (rh > 1023) rh = 1023;
        if (rv < 0) rv = 0;
        if (rv > 1023) rv = 1023;
      end
      if ($urandom_range(0, 7) == 0) rb = !rb;
      drive(bit'($urandom_range(0, 1)), rh, rv, rb);
      out_ready = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
    end
    idle(1);
    out_ready = 1'b1;
    idle(40);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
